// File: rtl/cache_pkg.sv
// Shared definitions for the N-way data cache: memory-op encodings, the
// controller state type, and the byte-lane / load-extension helpers.
package cache_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } cache_state_t;

  // Stores only distinguish size through the low two funct3 bits.
  function automatic logic [31:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
    logic [31:0] m;
    case (op[1:0])
      2'b00:   m = 32'h0000_00FF << {off, 3'b000};
      2'b01:   m = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data across all candidate lanes; the mask picks one.
  function automatic logic [31:0] store_align(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] v;
    case (op[1:0])
      2'b00:   v = {4{wd[7:0]}};
      2'b01:   v = {2{wd[15:0]}};
      default: v = wd;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      MEMOP_B:  v = {{24{b[7]}}, b};
      MEMOP_H:  v = {{16{h[15]}}, h};
      MEMOP_BU: v = {24'h0, b};
      MEMOP_HU: v = {16'h0, h};
      default:  v = word;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracking per set. Age 0 is most recent, WAYS-1 is the
// replacement candidate; ages in a set always form a permutation.
module cache_lru #(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    touch_i,
  input  logic [$clog2(SETS)-1:0] set_i,
  input  logic [$clog2(WAYS)-1:0] way_i,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int AGE_W = $clog2(WAYS);

  logic [AGE_W-1:0] age_q [SETS][WAYS];

  // Age update: touched way becomes youngest, younger ways age by one.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == way_i) begin
          age_q[set_i][w] <= '0;
        end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
        end
      end
    end
  end

  // Oldest way of the addressed set.
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[set_i][w] == AGE_W'(WAYS - 1)) begin
        victim_o = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/nway_cache_ctrl.sv
// Write-back, write-allocate N-way set-associative data cache with one-word
// lines. Misses stall the pipeline while a dirty victim is written back and
// the line is refilled; the held request then hits on the following cycle.
module nway_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [2:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);

  import cache_pkg::*;

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];

  cache_state_t state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_victim;
  logic [WAY_W-1:0] victim_sel;
  logic             access_hit;
  logic             refill_done;

  assign idx = addr_i[IDX_W+1:2];
  assign tag = addr_i[ADDR_WIDTH-1:IDX_W+2];
  assign off = addr_i[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index empty way takes precedence over the LRU candidate.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim_sel  = inv_found ? inv_way : lru_victim;
  assign access_hit  = (state_q == IDLE) && en_i && hit;
  assign refill_done = (state_q == REFILL) && mem_ack_i;

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .touch_i  (access_hit),
    .set_i    (idx),
    .way_i    (hit_way),
    .victim_o (lru_victim)
  );

  // Controller next-state and all pipeline/memory-side outputs.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    rd_o        = '0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          if (hit) begin
            if (!we_i) begin
              rd_o = load_ext(mem_op_i, off, data_q[idx][hit_way]);
            end
          end else begin
            stall_o  = 1'b1;
            victim_d = victim_sel;
            if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) begin
              state_d = WRITEBACK;
            end else begin
              state_d = REFILL;
            end
          end
        end
      end
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx][victim_q], idx, 2'b00};
        mem_wdata_o = data_q[idx][victim_q];
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched victim.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Line status: refill installs a clean line, a store hit marks it dirty.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (refill_done) begin
      valid_q[idx][victim_q] <= 1'b1;
      dirty_q[idx][victim_q] <= 1'b0;
    end else if (access_hit && we_i) begin
      dirty_q[idx][hit_way] <= 1'b1;
    end
  end

  // Tag/data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      data_q[idx][victim_q] <= mem_rdata_i;
      tag_q[idx][victim_q]  <= tag;
    end else if (access_hit && we_i) begin
      data_q[idx][hit_way] <= (data_q[idx][hit_way] & ~lane_mask(mem_op_i, off))
                            | (store_align(mem_op_i, wd_i) & lane_mask(mem_op_i, off));
    end
  end

endmodule

// File: tb/tb_nway_cache_ctrl.sv
// Directed bench for nway_cache_ctrl (WAYS=2, SETS=8). Inputs are driven on
// the falling edge and outputs sampled 1 time unit later.
module tb_nway_cache_ctrl;

  logic        clk;
  logic        reset_i;
  logic        en_i;
  logic        we_i;
  logic [2:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] wd_i;
  logic [31:0] rd_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int          n_pass;
  int          n_fail;
  int          n_chk;
  int          stall_cyc;
  int          n_txn;
  logic        txn_we    [4];
  logic [31:0] txn_addr  [4];
  logic [31:0] txn_wdata [4];
  logic [31:0] rd_hit;

  nway_cache_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .WAYS       (2),
    .SETS       (8)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .we_i        (we_i),
    .mem_op_i    (mem_op_i),
    .addr_i      (addr_i),
    .wd_i        (wd_i),
    .rd_o        (rd_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request and act as main memory until stall drops; each memory
  // transaction is acked on its lat-th request cycle. Ends on a falling edge
  // after the hit cycle has been clocked in.
  task automatic access(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic [31:0] fill);
    int k;
    en_i        = 1'b1;
    we_i        = w;
    mem_op_i    = op;
    addr_i      = a;
    wd_i        = d;
    mem_rdata_i = fill;
    stall_cyc   = 0;
    n_txn       = 0;
    k           = 0;
    #1;
    while (stall_o === 1'b1 && stall_cyc < 40) begin
      if (mem_req_o === 1'b1) begin
        if (k == 0 && n_txn < 4) begin
          txn_we[n_txn]    = mem_we_o;
          txn_addr[n_txn]  = mem_addr_o;
          txn_wdata[n_txn] = mem_wdata_o;
        end
        k++;
        if (k >= lat) begin
          mem_ack_i = 1'b1;
          n_txn++;
          k = 0;
        end
      end
      stall_cyc++;
      @(negedge clk);
      mem_ack_i = 1'b0;
      #1;
    end
    rd_hit = rd_o;
    @(negedge clk);
  endtask

  initial begin
    n_pass      = 0;
    n_fail      = 0;
    n_chk       = 0;
    reset_i     = 1'b1;
    en_i        = 1'b0;
    we_i        = 1'b0;
    mem_op_i    = 3'b010;
    addr_i      = '0;
    wd_i        = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_req", {31'b0, mem_req_o}, 32'h0);
    check("rst_we", {31'b0, mem_we_o}, 32'h0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_rd", rd_o, 32'h0);
    @(negedge clk);

    // Cold load, refill acked on the 3rd request cycle.
    en_i = 1'b1; we_i = 1'b0; mem_op_i = 3'b010; addr_i = 32'h10;
    #1;
    check("cold_stall_comb", {31'b0, stall_o}, 32'h1);
    check("cold_rd_miss", rd_o, 32'h0);
    @(negedge clk);
    access(1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF);
    check("cold_stall_cycles", 32'(stall_cyc), 32'd3);
    check("cold_ntxn", 32'(n_txn), 32'd1);
    check("cold_mem_we", {31'b0, txn_we[0]}, 32'h0);
    check("cold_mem_addr", txn_addr[0], 32'h10);
    check("cold_rd", rd_hit, 32'hDEADBEEF);

    // Byte ops on the resident line.
    access(1'b0, 3'b000, 32'h13, 32'h0, 1, 32'h0);
    check("lb_stall", 32'(stall_cyc), 32'd0);
    check("lb_rd", rd_hit, 32'hFFFFFFDE);
    access(1'b0, 3'b100, 32'h13, 32'h0, 1, 32'h0);
    check("lbu_rd", rd_hit, 32'h000000DE);
    access(1'b0, 3'b001, 32'h12, 32'h0, 1, 32'h0);
    check("lh_rd", rd_hit, 32'hFFFFDEAD);
    access(1'b0, 3'b101, 32'h10, 32'h0, 1, 32'h0);
    check("lhu_rd", rd_hit, 32'h0000BEEF);
    access(1'b1, 3'b001, 32'h12, 32'h1234, 1, 32'h0);
    check("sh_stall", 32'(stall_cyc), 32'd0);
    check("sh_rd_zero", rd_hit, 32'h0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h0);
    check("sh_lw_rd", rd_hit, 32'h1234BEEF);
    check("sh_lw_ntxn", 32'(n_txn), 32'd0);
    access(1'b1, 3'b000, 32'h11, 32'h5A, 1, 32'h0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h0);
    check("sb_lw_rd", rd_hit, 32'h12345AEF);

    // Dirty eviction: sw 0x10, lw 0x30, lw 0x50 all in set 4.
    access(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 1, 32'h0);
    check("sw_hit_stall", 32'(stall_cyc), 32'd0);
    access(1'b0, 3'b010, 32'h30, 32'h0, 2, 32'h33333333);
    check("lw30_stall", 32'(stall_cyc), 32'd3);
    check("lw30_addr", txn_addr[0], 32'h30);
    check("lw30_rd", rd_hit, 32'h33333333);
    access(1'b0, 3'b010, 32'h50, 32'h0, 2, 32'h55555555);
    check("evict_stall", 32'(stall_cyc), 32'd5);
    check("evict_ntxn", 32'(n_txn), 32'd2);
    check("evict_wb_we", {31'b0, txn_we[0]}, 32'h1);
    check("evict_wb_addr", txn_addr[0], 32'h10);
    check("evict_wb_data", txn_wdata[0], 32'hCAFEF00D);
    check("evict_rf_we", {31'b0, txn_we[1]}, 32'h0);
    check("evict_rf_addr", txn_addr[1], 32'h50);
    check("evict_rd", rd_hit, 32'h55555555);

    // LRU order from a clean cache, 1-cycle memory.
    en_i = 1'b0; reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    access(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h10101010);
    check("lru_lat1_stall", 32'(stall_cyc), 32'd2);
    access(1'b0, 3'b010, 32'h30, 32'h0, 1, 32'h30303030);
    access(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h0);
    check("lru_rehit", 32'(stall_cyc), 32'd0);
    access(1'b0, 3'b010, 32'h50, 32'h0, 1, 32'h50505050);
    check("lru_50_ntxn", 32'(n_txn), 32'd1);
    check("lru_50_addr", txn_addr[0], 32'h50);
    access(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h0);
    check("lru_10_kept_stall", 32'(stall_cyc), 32'd0);
    check("lru_10_kept_rd", rd_hit, 32'h10101010);
    access(1'b0, 3'b010, 32'h30, 32'h0, 1, 32'h30303030);
    check("lru_30_evicted", 32'(n_txn), 32'd1);

    // Reset while waiting on a refill.
    en_i = 1'b1; we_i = 1'b0; mem_op_i = 3'b010; addr_i = 32'h20;
    @(negedge clk);
    #1;
    check("mid_refill_req", {31'b0, mem_req_o}, 32'h1);
    reset_i = 1'b1; en_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("post_rst_req", {31'b0, mem_req_o}, 32'h0);
    check("post_rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    access(1'b0, 3'b010, 32'h20, 32'h0, 1, 32'h20202020);
    check("rst_remiss_ntxn", 32'(n_txn), 32'd1);
    check("rst_remiss_rd", rd_hit, 32'h20202020);

    // Spurious ack while idle.
    en_i = 1'b0; addr_i = 32'h20; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    #1;
    check("spur_stall", {31'b0, stall_o}, 32'h0);
    check("spur_rd", rd_o, 32'h0);
    check("spur_req", {31'b0, mem_req_o}, 32'h0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("spur_req_after", {31'b0, mem_req_o}, 32'h0);
    @(negedge clk);
    access(1'b0, 3'b010, 32'h20, 32'h0, 1, 32'h0);
    check("spur_hit_stall", 32'(stall_cyc), 32'd0);
    check("spur_hit_rd", rd_hit, 32'h20202020);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
